// File: rtl/writeback_stage_if.sv
// writeback_stage_if: retiring-instruction, data-memory and register-file write bundle for the writeback stage
interface writeback_stage_if;
  logic        in_valid;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic [4:0]  in_dest;
  logic [31:0] in_alu_result;
  logic [1:0]  in_load_size;
  logic        in_load_unsigned;
  logic [1:0]  in_byte_offset;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        stall_out;
  logic [31:0] wb_data;
  logic [4:0]  wb_address;
  logic        wb_write_enable;
  logic        align_error;
  logic        load_timeout;
  modport master (
    output in_valid, in_reg_write, in_mem_to_reg, in_dest, in_alu_result, in_load_size,
           in_load_unsigned, in_byte_offset, mem_ready, mem_rdata, flush,
    input  stall_out, wb_data, wb_address, wb_write_enable, align_error, load_timeout
  );
  modport slave (
    input  in_valid, in_reg_write, in_mem_to_reg, in_dest, in_alu_result, in_load_size,
           in_load_unsigned, in_byte_offset, mem_ready, mem_rdata, flush,
    output stall_out, wb_data, wb_address, wb_write_enable, align_error, load_timeout
  );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: selects ALU result or extracted load data and drives the register-file write port.
// Define WB_LOAD_TIMEOUT_EN to abandon loads after TIMEOUT_CYCLES cycles without mem_ready.
module writeback_stage
`ifdef WB_LOAD_TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = 16)
`endif
(
  input logic clock,
  input logic reset,
  writeback_stage_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT_LOAD = 1'b1;
  logic [0:0] state;
  logic [4:0] ld_dest;
  logic       ld_reg_write;
  logic [1:0] ld_size;
  logic       ld_unsigned;
  logic [1:0] ld_offset;
  logic       misaligned;
  logic [31:0] shifted;
  logic [15:0] half;
  logic [31:0] load_value;
  assign bus.stall_out = (state == WAIT_LOAD);
  assign misaligned = (bus.in_load_size == 2'b01 && bus.in_byte_offset[0]) ||
                      (bus.in_load_size[1] && bus.in_byte_offset != 2'b00);
  // big-endian lanes: offset 0 is the most significant byte
  always_comb begin
    shifted = bus.mem_rdata >> {~ld_offset, 3'b000};
    half = ld_offset[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
    load_value = ld_size == 2'b00 ? {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]} :
                 ld_size == 2'b01 ? {{16{~ld_unsigned & half[15]}}, half} : bus.mem_rdata;
  end
`ifdef WB_LOAD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
`else
  assign bus.load_timeout = 1'b0;
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ld_dest <= '0;
      ld_reg_write <= 1'b0;
      ld_size <= '0;
      ld_unsigned <= 1'b0;
      ld_offset <= '0;
      bus.wb_data <= '0;
      bus.wb_address <= '0;
      bus.wb_write_enable <= 1'b0;
      bus.align_error <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
      bus.load_timeout <= 1'b0;
      cnt <= '0;
`endif
    end else begin
      bus.wb_data <= '0;
      bus.wb_address <= '0;
      bus.wb_write_enable <= 1'b0;
      bus.align_error <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
      bus.load_timeout <= 1'b0;
`endif
      if (state == IDLE) begin
        if (bus.in_valid && !bus.flush) begin
          if (!bus.in_mem_to_reg) begin
            bus.wb_data <= bus.in_alu_result;
            bus.wb_address <= bus.in_dest;
            bus.wb_write_enable <= bus.in_reg_write && (bus.in_dest != 5'd0);
          end else if (misaligned) begin
            bus.align_error <= 1'b1;
          end else begin
            ld_dest <= bus.in_dest;
            ld_reg_write <= bus.in_reg_write;
            ld_size <= bus.in_load_size;
            ld_unsigned <= bus.in_load_unsigned;
            ld_offset <= bus.in_byte_offset;
            state <= WAIT_LOAD;
`ifdef WB_LOAD_TIMEOUT_EN
            cnt <= '0;
`endif
          end
        end
      end else if (bus.flush) begin
        state <= IDLE;
      end else if (bus.mem_ready) begin
        bus.wb_data <= load_value;
        bus.wb_address <= ld_dest;
        bus.wb_write_enable <= ld_reg_write && (ld_dest != 5'd0);
        state <= IDLE;
      end
`ifdef WB_LOAD_TIMEOUT_EN
      else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        state <= IDLE;
        bus.load_timeout <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
`endif
    end
  end
endmodule
